// File: rtl/ysyx_24110015_icache.sv
// Direct-mapped read-only instruction cache for the IFU fetch path.
// Hits come from local line storage. A miss refills the whole line with one
// AXI4 INCR burst. The cache also supports fence.i invalidation and keeps
// saturating hit/miss counters.
module ysyx_24110015_icache #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_LINES  = 16,
  parameter logic [3:0]  AXI_ID     = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_inst,
  output logic        rsp_err,
  input  logic        fence_i,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic [3:0]  rid,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int unsigned WO_W  = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W = WO_W + 2;
  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = 32 - OFF_W - IDX_W;
  localparam int unsigned DEPTH = NUM_LINES * LINE_WORDS;
  // Wide enough that an overlong burst cannot alias back to a legal length.
  localparam int unsigned CNT_W = 9;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    REFILL_AR = 3'd2,
    REFILL_R  = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t               state;
  logic [31:0]          addr_q;
  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [31:0]          data_mem [DEPTH];
  logic [CNT_W-1:0]     beat;
  logic                 err_q;
  logic                 fence_pend;

  logic [TAG_W-1:0]     a_tag;
  logic [IDX_W-1:0]     a_idx;
  logic [WO_W-1:0]      a_wo;
  logic                 hit;
  logic [31:0]          hit_word;
  logic                 r_fire;
  logic                 beat_keep;
  logic                 last_err;
  logic                 unused_bits;

  // Split the latched fetch address into tag, line index and word offset.
  assign a_tag = addr_q[31 -: TAG_W];
  assign a_idx = addr_q[OFF_W +: IDX_W];
  assign a_wo  = addr_q[2 +: WO_W];

  assign hit       = valid[a_idx] && (tag_mem[a_idx] == a_tag);
  assign hit_word  = data_mem[{a_idx, a_wo}];
  assign r_fire    = rvalid && rready;
  assign beat_keep = beat < CNT_W'(LINE_WORDS);
  // Error state of the whole burst, evaluated on the rlast beat.
  assign last_err  = err_q || (rresp != 2'b00) || (beat != CNT_W'(LINE_WORDS - 1));

  assign arid    = AXI_ID;
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  assign unused_bits = ^{addr_q[1:0], rid};

  // Line storage: data beats and the tag of a good refill. These arrays have no reset.
  always_ff @(posedge clk) begin
    if (r_fire && beat_keep) begin
      data_mem[{a_idx, beat[WO_W-1:0]}] <= rdata;
    end
    if (r_fire && rlast && !last_err) begin
      tag_mem[a_idx] <= a_tag;
    end
  end

  // Control FSM with registered outputs, valid bits and performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      valid      <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_inst   <= '0;
      arvalid    <= 1'b0;
      araddr     <= '0;
      rready     <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      addr_q     <= '0;
      beat       <= '0;
      err_q      <= 1'b0;
      fence_pend <= 1'b0;
    end else begin
      if (fence_i && (state != IDLE)) begin
        fence_pend <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (fence_i) begin
            valid <= '0;
          end
          if (req_valid) begin
            addr_q    <= req_addr;
            req_ready <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            rsp_inst  <= hit_word;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
            if (hit_cnt != 32'hFFFF_FFFF) begin
              hit_cnt <= hit_cnt + 32'd1;
            end
          end else begin
            araddr  <= {addr_q[31:OFF_W], OFF_W'(0)};
            arvalid <= 1'b1;
            state   <= REFILL_AR;
            if (miss_cnt != 32'hFFFF_FFFF) begin
              miss_cnt <= miss_cnt + 32'd1;
            end
          end
        end
        REFILL_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            beat    <= '0;
            err_q   <= 1'b0;
            state   <= REFILL_R;
          end
        end
        REFILL_R: begin
          if (rvalid) begin
            if (beat != '1) begin
              beat <= beat + CNT_W'(1);
            end
            if (beat_keep && (beat[WO_W-1:0] == a_wo)) begin
              rsp_inst <= rdata;
            end
            if (rresp != 2'b00) begin
              err_q <= 1'b1;
            end
            if (rlast) begin
              rready    <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_err   <= last_err;
              state     <= RESP;
              if (last_err) begin
                valid[a_idx] <= 1'b0;
                rsp_inst     <= '0;
              end else begin
                valid[a_idx] <= 1'b1;
              end
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
            if (fence_pend || fence_i) begin
              valid      <= '0;
              fence_pend <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
